// File: rtl/regfile_sb.sv
// regfile_sb
//   Register file with per-register busy bits (scoreboard) for the pipelined
//   LC-3 datapath. Decode reads operands and reserves destinations; writeback
//   writes results and releases the reservation. After reset the array is
//   zeroed one register per cycle so it can map onto RAM that has no reset.
//
// Parameters
//   WIDTH  : data width of each register
//   NREGS  : number of registers (power of two, >= 2)
//   NRD    : number of read ports (1..4)
//   BYPASS : 1 = forward same-cycle write data to matching read ports
//
// Ports
//   Clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   we       in   write enable (writeback)
//   waddr    in   write register index
//   wdata    in   write data
//   rsv      in   reserve request, marks rsv_addr busy
//   rsv_addr in   register to reserve
//   raddr    in   packed read indices, port p at [p*AW +: AW]
//   rdata    out  packed read data, port p at [p*WIDTH +: WIDTH]
//   rbusy    out  busy flag of the register each read port addresses
//   ready    out  1 once the array has been cleared and ports are active
module regfile_sb #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                           Clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [$clog2(NREGS)-1:0]       waddr,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           rsv,
  input  logic [$clog2(NREGS)-1:0]       rsv_addr,
  input  logic [NRD*$clog2(NREGS)-1:0]   raddr,
  output logic [NRD*WIDTH-1:0]           rdata,
  output logic [NRD-1:0]                 rbusy,
  output logic                           ready
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [CW-1:0]     cnt_reg;
  logic [NREGS-1:0]  busy_reg;
  logic [WIDTH-1:0]  mem [NREGS];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_reg <= ST_RST;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RST:   state_next = ST_CLEAR;
      // Leave after the cycle that zeroes the last register.
      ST_CLEAR: if (cnt_reg == CW'(NREGS - 1)) state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_RST;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    if (state_reg == ST_RUN) ready = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Clear counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_CLEAR) begin
      cnt_reg <= cnt_reg + CW'(1);
    end else if (state_reg == ST_RST) begin
      cnt_reg <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array: single write port, no reset, so it can be mapped to RAM.
  // The clear sequence and writeback share the one write port; they are
  // mutually exclusive because writes are only accepted in RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!reset && state_reg == ST_CLEAR) begin
      mem[cnt_reg[AW-1:0]] <= '0;
    end else if (!reset && ready && we) begin
      mem[waddr] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy bits. A reservation and a write to the same register in one cycle
  // leave the register busy: the reservation names a newer producer.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
      always_ff @(posedge Clk) begin
        if (reset) begin
          busy_reg[gi] <= 1'b0;
        end else if (ready) begin
          if (rsv && rsv_addr == AW'(gi)) begin
            busy_reg[gi] <= 1'b1;
          end else if (we && waddr == AW'(gi)) begin
            busy_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read ports: combinational, independent, forced to zero until ready.
  // With bypass, a same-cycle write to the addressed register supplies the
  // data and reports not-busy (the result is available now). Reservations
  // are not forwarded, so rbusy rises only from the cycle after rsv.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] ra;
      logic          hit;

      assign ra  = raddr[gi*AW +: AW];
      assign hit = (BYPASS != 0) && we && (ra == waddr);

      assign rdata[gi*WIDTH +: WIDTH] = !ready ? '0    :
                                        hit    ? wdata :
                                                 mem[ra];
      assign rbusy[gi] = ready && !hit && busy_reg[ra];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
//   Directed test of regfile_sb. Two instances share all inputs: one with
//   forwarding (BYPASS=1, suffix _b1) and one without (BYPASS=0, suffix _b0),
//   so the same-cycle and next-cycle behaviour are checked side by side.
//   Inputs change 1 time unit after a rising edge; outputs are sampled a
//   further 1 unit later, well away from the next edge.
module tb_regfile_sb;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        rsv = 1'b0;
  logic [2:0]  rsv_addr = '0;
  logic [5:0]  raddr = '0;

  logic [31:0] rdata_b1, rdata_b0;
  logic [1:0]  rbusy_b1, rbusy_b0;
  logic        ready_b1, ready_b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  regfile_sb #(.WIDTH(16), .NREGS(8), .NRD(2), .BYPASS(1)) dut_b1 (
    .Clk(Clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv(rsv), .rsv_addr(rsv_addr), .raddr(raddr),
    .rdata(rdata_b1), .rbusy(rbusy_b1), .ready(ready_b1)
  );

  regfile_sb #(.WIDTH(16), .NREGS(8), .NRD(2), .BYPASS(0)) dut_b0 (
    .Clk(Clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .rsv(rsv), .rsv_addr(rsv_addr), .raddr(raddr),
    .rdata(rdata_b0), .rbusy(rbusy_b0), .ready(ready_b0)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    we  = 1'b0;
    rsv = 1'b0;
  endtask

  // Reset/clear sequence, including a write+reserve issued during CLEAR.
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 20 && !ready_b1; k++) step();
    n_cmp++;
    if (ready_b1 !== 1'b1 || ready_b0 !== 1'b1) begin
      n_bad++;
      $display("FAIL powerup_ready got %b/%b expected 1/1", ready_b1, ready_b0);
    end

    // Fill every register with garbage and mark all of them busy.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 16'hA000 | 16'(i);
      rsv = 1'b1; rsv_addr = 3'(i);
      step();
    end
    idle();
    raddr = {3'd7, 3'd2};
    #1;
    $display("[%0t] test_reset: garbage loaded, rdata=%h rbusy=%b", $time, rdata_b0, rbusy_b0);
    n_cmp++;
    if (rdata_b0 !== {16'hA007, 16'hA002} || rbusy_b0 !== 2'b11) begin
      n_bad++;
      $display("FAIL preload got %h/%b expected a007a002/11", rdata_b0, rbusy_b0);
    end

    // One-cycle reset pulse.
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (ready_b1 !== 1'b0 || rdata_b1 !== 32'h0 || rbusy_b1 !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_state got ready=%b rdata=%h rbusy=%b expected 0/0/00",
               ready_b1, rdata_b1, rbusy_b1);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 4) begin
        // Issued during CLEAR (cnt=3); must be ignored.
        we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF;
        rsv = 1'b1; rsv_addr = 3'd0;
      end else begin
        idle();
      end
      #1;
      $display("[%0t] test_reset: clear cycle %0d ready=%b", $time, k, ready_b1);
      n_cmp++;
      if (ready_b1 !== 1'b0 || ready_b0 !== 1'b0 || rdata_b1 !== 32'h0 || rbusy_b1 !== 2'b00) begin
        n_bad++;
        $display("FAIL clear_cycle_%0d got ready=%b/%b rdata=%h rbusy=%b expected 0/0/0/00",
                 k, ready_b1, ready_b0, rdata_b1, rbusy_b1);
      end
    end
    step();
    n_cmp++;
    if (ready_b1 !== 1'b1 || ready_b0 !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_clear got %b/%b expected 1/1", ready_b1, ready_b0);
    end
    for (int i = 0; i < 8; i++) begin
      raddr = {3'(i), 3'(i)};
      #1;
      $display("[%0t] test_reset: read reg%0d rdata=%h rbusy=%b", $time, i, rdata_b1[15:0], rbusy_b1);
      n_cmp++;
      if (rdata_b1 !== 32'h0 || rdata_b0 !== 32'h0 || rbusy_b1 !== 2'b00 || rbusy_b0 !== 2'b00) begin
        n_bad++;
        $display("FAIL cleared_reg%0d got %h/%h busy %b/%b expected 0/0 busy 00/00",
                 i, rdata_b1, rdata_b0, rbusy_b1, rbusy_b0);
      end
    end
  endtask

  task automatic test_write();
    raddr = {3'd3, 3'd3};
    we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
    #1;
    $display("[%0t] test_write: reg3<=beef, same cycle b0=%h b1=%h", $time, rdata_b0[15:0], rdata_b1[15:0]);
    n_cmp++;
    if (rdata_b0[15:0] !== 16'h0000) begin
      n_bad++;
      $display("FAIL write_nobyp_same got %h expected 0000", rdata_b0[15:0]);
    end
    n_cmp++;
    if (rdata_b1[15:0] !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL write_byp_same got %h expected beef", rdata_b1[15:0]);
    end
    step();
    idle();
    #1;
    $display("[%0t] test_write: next cycle b0=%h", $time, rdata_b0);
    n_cmp++;
    if (rdata_b0 !== 32'hBEEF_BEEF || rdata_b1 !== 32'hBEEF_BEEF) begin
      n_bad++;
      $display("FAIL write_next got %h/%h expected beefbeef", rdata_b0, rdata_b1);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 3'd2; wdata = 16'h5A5A;
    step();
    we = 1'b1; waddr = 3'd5; wdata = 16'h1234;
    raddr = {3'd2, 3'd5};
    #1;
    $display("[%0t] test_bypass: reg5<=1234 b1=%h b0=%h", $time, rdata_b1, rdata_b0);
    n_cmp++;
    if (rdata_b1 !== {16'h5A5A, 16'h1234}) begin
      n_bad++;
      $display("FAIL bypass_b1 got %h expected 5a5a1234", rdata_b1);
    end
    n_cmp++;
    if (rdata_b0 !== {16'h5A5A, 16'h0000}) begin
      n_bad++;
      $display("FAIL bypass_b0 got %h expected 5a5a0000", rdata_b0);
    end
    step();
    idle();
  endtask

  task automatic test_scoreboard();
    rsv = 1'b1; rsv_addr = 3'd6;
    raddr = {3'd6, 3'd6};
    #1;
    $display("[%0t] test_scoreboard: reserve reg6, same cycle rbusy=%b", $time, rbusy_b1);
    n_cmp++;
    if (rbusy_b1 !== 2'b00 || rbusy_b0 !== 2'b00) begin
      n_bad++;
      $display("FAIL rsv_same_cycle got %b/%b expected 00/00", rbusy_b1, rbusy_b0);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (rbusy_b1 !== 2'b11 || rbusy_b0 !== 2'b11) begin
      n_bad++;
      $display("FAIL rsv_next_cycle got %b/%b expected 11/11", rbusy_b1, rbusy_b0);
    end
    we = 1'b1; waddr = 3'd6; wdata = 16'h00AA;
    #1;
    $display("[%0t] test_scoreboard: write reg6<=00aa rbusy b1=%b b0=%b", $time, rbusy_b1, rbusy_b0);
    n_cmp++;
    if (rbusy_b1 !== 2'b00 || rdata_b1[15:0] !== 16'h00AA) begin
      n_bad++;
      $display("FAIL sb_write_byp got busy=%b data=%h expected 00/00aa", rbusy_b1, rdata_b1[15:0]);
    end
    n_cmp++;
    if (rbusy_b0 !== 2'b11 || rdata_b0[15:0] !== 16'h0000) begin
      n_bad++;
      $display("FAIL sb_write_nobyp got busy=%b data=%h expected 11/0000", rbusy_b0, rdata_b0[15:0]);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (rbusy_b0 !== 2'b00 || rdata_b0[15:0] !== 16'h00AA || rbusy_b1 !== 2'b00) begin
      n_bad++;
      $display("FAIL sb_after got busy=%b/%b data=%h expected 00/00 00aa",
               rbusy_b0, rbusy_b1, rdata_b0[15:0]);
    end
  endtask

  task automatic test_simultaneous();
    rsv = 1'b1; rsv_addr = 3'd4;
    we = 1'b1; waddr = 3'd4; wdata = 16'h7777;
    raddr = {3'd4, 3'd4};
    #1;
    $display("[%0t] test_simultaneous: rsv+write reg4 b1=%h/%b", $time, rdata_b1, rbusy_b1);
    n_cmp++;
    if (rdata_b1 !== 32'h7777_7777 || rbusy_b1 !== 2'b00 || rbusy_b0 !== 2'b00) begin
      n_bad++;
      $display("FAIL simul_same got %h busy %b/%b expected 77777777 busy 00/00",
               rdata_b1, rbusy_b1, rbusy_b0);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (rdata_b0 !== 32'h7777_7777 || rbusy_b0 !== 2'b11 || rbusy_b1 !== 2'b11) begin
      n_bad++;
      $display("FAIL simul_after got %h busy %b/%b expected 77777777 busy 11/11",
               rdata_b0, rbusy_b0, rbusy_b1);
    end

    // Reserve and write different registers in the same cycle.
    rsv = 1'b1; rsv_addr = 3'd1;
    we = 1'b1; waddr = 3'd6; wdata = 16'h0BAD;
    raddr = {3'd6, 3'd1};
    step();
    idle();
    #1;
    $display("[%0t] test_simultaneous: rsv reg1 + write reg6 b0=%h/%b", $time, rdata_b0, rbusy_b0);
    n_cmp++;
    if (rbusy_b0 !== 2'b01 || rbusy_b1 !== 2'b01 || rdata_b0[31:16] !== 16'h0BAD) begin
      n_bad++;
      $display("FAIL split_rsv_wr got busy %b/%b data %h expected 01/01 0bad",
               rbusy_b0, rbusy_b1, rdata_b0[31:16]);
    end

    // Reserving an already-busy register keeps it busy.
    rsv = 1'b1; rsv_addr = 3'd1;
    step();
    idle();
    #1;
    n_cmp++;
    if (rbusy_b0[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL rsv_twice got %b expected 1", rbusy_b0[0]);
    end

    // Writing a busy register releases it.
    we = 1'b1; waddr = 3'd4; wdata = 16'h1111;
    raddr = {3'd4, 3'd4};
    step();
    idle();
    #1;
    $display("[%0t] test_simultaneous: write busy reg4 b0=%h/%b", $time, rdata_b0, rbusy_b0);
    n_cmp++;
    if (rdata_b0 !== 32'h1111_1111 || rbusy_b0 !== 2'b00) begin
      n_bad++;
      $display("FAIL write_busy got %h/%b expected 11111111/00", rdata_b0, rbusy_b0);
    end
  endtask

  task automatic test_back_to_back();
    raddr = {3'd3, 3'd3};
    we = 1'b1; waddr = 3'd3; wdata = 16'h1111;
    #1;
    n_cmp++;
    if (rdata_b1[15:0] !== 16'h1111 || rdata_b0[15:0] !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL b2b_first got %h/%h expected 1111/beef", rdata_b1[15:0], rdata_b0[15:0]);
    end
    step();
    wdata = 16'h2222;
    #1;
    $display("[%0t] test_back_to_back: second write b1=%h b0=%h", $time, rdata_b1[15:0], rdata_b0[15:0]);
    n_cmp++;
    if (rdata_b1[15:0] !== 16'h2222 || rdata_b0[15:0] !== 16'h1111) begin
      n_bad++;
      $display("FAIL b2b_second got %h/%h expected 2222/1111", rdata_b1[15:0], rdata_b0[15:0]);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (rdata_b1 !== 32'h2222_2222 || rdata_b0 !== 32'h2222_2222) begin
      n_bad++;
      $display("FAIL b2b_after got %h/%h expected 22222222", rdata_b1, rdata_b0);
    end
  endtask

  task automatic test_reset_mid_clear();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) step();   // now in CLEAR with cnt=5
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ready_b1 !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_clear_ready got %b expected 0", ready_b1);
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if (ready_b1 !== 1'b0 || ready_b0 !== 1'b0) begin
        n_bad++;
        $display("FAIL restart_cycle_%0d got %b/%b expected 0/0", k, ready_b1, ready_b0);
      end
    end
    step();
    raddr = {3'd4, 3'd1};
    #1;
    $display("[%0t] test_reset_mid_clear: ready=%b rdata=%h rbusy=%b", $time, ready_b1, rdata_b1, rbusy_b1);
    n_cmp++;
    if (ready_b1 !== 1'b1 || rdata_b1 !== 32'h0 || rbusy_b1 !== 2'b00) begin
      n_bad++;
      $display("FAIL restart_done got ready=%b rdata=%h rbusy=%b expected 1/0/00",
               ready_b1, rdata_b1, rbusy_b1);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
